// File: rtl/inst_loader_if.sv
// Bundle between the loader, CPU fetch path, UART receiver and instruction memory.
// The loader takes the master modport; the environment (CPU/UART/memory) takes slave.
interface inst_loader_if #(
   parameter int ADDR_W = 8
);
   logic              load_req;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic [31:0]       cpu_addr;
   logic [31:0]       cpu_data;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_rdata;
   logic [31:0]       mem_wdata;
   logic              mem_we;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;

   modport master (
      input  load_req, rx_data, rx_valid, cpu_addr, mem_rdata,
      output cpu_data, mem_addr, mem_wdata, mem_we, cpu_hold, load_done, load_err
   );

   modport slave (
      output load_req, rx_data, rx_valid, cpu_addr, mem_rdata,
      input  cpu_data, mem_addr, mem_wdata, mem_we, cpu_hold, load_done, load_err
   );
endinterface

// File: rtl/inst_loader.sv
// Instruction-memory port arbiter and UART program loader (count header, LE words).
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module inst_loader #(
   parameter int ROM_SIZE = 256,
   parameter int ADDR_W   = 8
) (
   input  logic          clk,
   input  logic          reset,
   inst_loader_if.master bus
);
   typedef enum logic [2:0] {
      S_RUN, S_CNT_LO, S_CNT_HI, S_DATA,
`ifdef LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_DONE, S_ERR
   } state_t;

   state_t          r_state;
   logic            r_load_req_q;
   logic [15:0]     r_cnt;
   logic [ADDR_W:0] r_widx;
   logic [1:0]      r_bidx;
   logic [23:0]     r_asm;
   logic [31:0]     r_wdata;
   logic            r_we;
   logic            r_hold;
   logic            r_done;
   logic            r_err;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]      r_csum;
`endif

   logic            w_rise;
   logic [15:0]     w_n;
   logic [15:0]     w_widx_nx;
   logic            w_last;
   logic            w_in_rom;
   logic            w_unused;

   assign w_rise    = bus.load_req & ~r_load_req_q;
   assign w_n       = {bus.rx_data, r_cnt[7:0]};
   assign w_widx_nx = 16'(r_widx) + 16'd1;
   assign w_last    = (w_widx_nx == r_cnt);
   assign w_in_rom  = (bus.cpu_addr[30:2] < 29'(ROM_SIZE));
   assign w_unused  = ^{bus.cpu_addr[31], bus.cpu_addr[1:0]};

   // Fetch path is purely combinational so the CPU sees zero-latency reads in RUN.
   assign bus.mem_addr  = (r_state == S_RUN) ? bus.cpu_addr[ADDR_W+1:2] : r_widx[ADDR_W-1:0];
   assign bus.cpu_data  = ((r_state == S_RUN) && w_in_rom) ? bus.mem_rdata : 32'h0;
   assign bus.mem_wdata = r_wdata;
   assign bus.mem_we    = r_we;
   assign bus.cpu_hold  = r_hold;
   assign bus.load_done = r_done;
   assign bus.load_err  = r_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_RUN;
         r_load_req_q <= 1'b0;
         r_cnt        <= '0;
         r_widx       <= '0;
         r_bidx       <= '0;
         r_asm        <= '0;
         r_wdata      <= '0;
         r_we         <= 1'b0;
         r_hold       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         r_csum       <= '0;
`endif
      end else begin
         r_load_req_q <= bus.load_req;
         r_we         <= 1'b0;
         r_done       <= 1'b0;
         // The index advances only after the write cycle, so mem_addr holds during mem_we.
         if (r_we) r_widx <= r_widx + 1'b1;

         case (r_state)
            S_RUN: begin
               if (w_rise) begin
                  r_state <= S_CNT_LO;
                  r_hold  <= 1'b1;
               end
            end
            S_CNT_LO: begin
               if (bus.rx_valid) begin
                  r_cnt[7:0] <= bus.rx_data;
                  r_state    <= S_CNT_HI;
               end
            end
            S_CNT_HI: begin
               r_widx <= '0;
               r_bidx <= '0;
`ifdef LOADER_CHECKSUM_EN
               r_csum <= '0;
`endif
               if (bus.rx_valid) begin
                  r_cnt <= w_n;
                  if ((w_n == 16'd0) || (w_n > 16'(ROM_SIZE))) begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (bus.rx_valid) begin
                  r_asm  <= {bus.rx_data, r_asm[23:8]};
                  r_bidx <= r_bidx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  r_csum <= r_csum ^ bus.rx_data;
`endif
                  if (r_bidx == 2'd3) begin
                     r_wdata <= {bus.rx_data, r_asm};
                     r_we    <= 1'b1;
                     if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state <= S_CHECK;
`else
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
`endif
                     end
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (bus.rx_valid) begin
                  if (bus.rx_data == r_csum) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                  end
               end
            end
`endif
            S_DONE: begin
               r_state <= S_RUN;
               r_hold  <= 1'b0;
            end
            S_ERR: begin
               if (w_rise) begin
                  r_state <= S_CNT_LO;
                  r_err   <= 1'b0;
               end
            end
            default: r_state <= S_RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_inst_loader.sv
// Scoreboarded bench for inst_loader: memory writes and done pulses are checked by a
// monitor against queued expectations; fetch/status outputs are checked directly.
module tb_inst_loader;
   logic clk;
   logic reset;
   logic mem_init;

   inst_loader_if #(.ADDR_W(8)) bus ();

   inst_loader #(.ROM_SIZE(256), .ADDR_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory model
   logic [31:0] mem [256];
   assign bus.mem_rdata = mem[bus.mem_addr];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
         mem[1] <= 32'h0800_002d;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;
   wr_t exp_q[$];

   int n_cmp, n_err;
   int mon_cmp, mon_err, mon_done;
   logic prev_done;

   // Monitor: pops one expected write per mem_we and checks the done/hold relation.
   initial begin
      mon_cmp = 0; mon_err = 0; mon_done = 0; prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.mem_we) begin
            mon_cmp++;
            if (exp_q.size() == 0) begin
               mon_err++;
               $display("FAIL unexpected_write: addr %0d data %h, none expected", bus.mem_addr, bus.mem_wdata);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
                  mon_err++;
                  $display("FAIL write: got addr %0d data %h, expected addr %0d data %h",
                           bus.mem_addr, bus.mem_wdata, e.addr, e.data);
               end
            end
         end
         if (prev_done) begin
            mon_cmp++;
            if (bus.cpu_hold !== 1'b0) begin
               mon_err++;
               $display("FAIL hold_after_done: got %b expected 0", bus.cpu_hold);
            end
         end
         if (bus.load_done) begin
            mon_done++;
            mon_cmp++;
            if (bus.cpu_hold !== 1'b1) begin
               mon_err++;
               $display("FAIL hold_during_done: got %b expected 1", bus.cpu_hold);
            end
         end
         prev_done = bus.load_done;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_all(input logic [7:0] q[$]);
      foreach (q[i]) send(q[i]);
   endtask

   task automatic pulse_req();
      bus.load_req = 1'b1;
      cycles(1);
      bus.load_req = 1'b0;
   endtask

   task automatic push_wr(input logic [7:0] a, input logic [31:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   logic [7:0] bq[$];

   initial begin
      n_cmp = 0; n_err = 0;
      reset = 1'b1; mem_init = 1'b1;
      bus.load_req = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
      bus.cpu_addr = 32'h0;
      cycles(3);
      reset = 1'b0; mem_init = 1'b0;
      cycles(1);

      // 1. Reset state and fetch
      bus.cpu_addr = 32'h0000_0004;
      #1;
      chk("rst_mem_addr",  32'(bus.mem_addr), 32'd1);
      chk("rst_cpu_data",  bus.cpu_data, 32'h0800_002d);
      chk("rst_cpu_hold",  32'(bus.cpu_hold), 32'd0);
      chk("rst_mem_we",    32'(bus.mem_we), 32'd0);
      chk("rst_load_done", 32'(bus.load_done), 32'd0);
      chk("rst_load_err",  32'(bus.load_err), 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);

      // 2. Good load, back-to-back bytes
      push_wr(8'd0, 32'h0800_0003);
      push_wr(8'd1, 32'h0800_002d);
      pulse_req();
      chk("hold_after_rise", 32'(bus.cpu_hold), 32'd1);
      chk("nop_while_load",  bus.cpu_data, 32'h0);
      bq = '{8'h02, 8'h00, 8'h03, 8'h00, 8'h00, 8'h08, 8'h2d, 8'h00, 8'h00, 8'h08};
`ifdef LOADER_CHECKSUM_EN
      bq.push_back(8'h2e);
`endif
      send_all(bq);
      cycles(3);
      chk("good_done_count", 32'(mon_done), 32'd1);
      chk("good_err",        32'(bus.load_err), 32'd0);
      chk("good_hold",       32'(bus.cpu_hold), 32'd0);
      chk("good_writes_all", 32'(exp_q.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
      // 3. Bad checksum: writes still land, then ERR
      push_wr(8'd0, 32'h0800_0003);
      push_wr(8'd1, 32'h0800_002d);
      pulse_req();
      bq = '{8'h02, 8'h00, 8'h03, 8'h00, 8'h00, 8'h08, 8'h2d, 8'h00, 8'h00, 8'h08, 8'h00};
      send_all(bq);
      cycles(2);
      chk("csum_err",        32'(bus.load_err), 32'd1);
      chk("csum_hold",       32'(bus.cpu_hold), 32'd1);
      chk("csum_no_done",    32'(mon_done), 32'd1);
      chk("csum_writes_all", 32'(exp_q.size()), 32'd0);
      pulse_req();
      chk("csum_err_clear",  32'(bus.load_err), 32'd0);
`else
      pulse_req();
`endif

      // 4. Bad count: N=257, then N=0
      send(8'h01);
      send(8'h01);
      chk("cnt257_err",  32'(bus.load_err), 32'd1);
      chk("cnt257_hold", 32'(bus.cpu_hold), 32'd1);
      pulse_req();
      chk("err_clear_by_rise", 32'(bus.load_err), 32'd0);
      send(8'h00);
      send(8'h00);
      chk("cnt0_err", 32'(bus.load_err), 32'd1);
      cycles(2);
      chk("cnt0_err_sticky", 32'(bus.load_err), 32'd1);

      // Single-word load with idle gaps and ignored load_req pulses mid-load
      push_wr(8'd0, 32'h1234_5678);
      pulse_req();
      bq = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef LOADER_CHECKSUM_EN
      bq.push_back(8'h08);
`endif
      foreach (bq[i]) begin
         send(bq[i]);
         if (i < bq.size() - 1) begin
            pulse_req();
            cycles(1);
         end
      end
      cycles(3);
      chk("n1_done_count", 32'(mon_done), 32'd2);
      chk("n1_err",        32'(bus.load_err), 32'd0);
      chk("n1_hold",       32'(bus.cpu_hold), 32'd0);
      chk("n1_writes_all", 32'(exp_q.size()), 32'd0);

      // 5. Reset mid-load after two data bytes
      pulse_req();
      bq = '{8'h02, 8'h00, 8'h03, 8'h00};
      send_all(bq);
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      chk("midrst_hold", 32'(bus.cpu_hold), 32'd0);
      chk("midrst_err",  32'(bus.load_err), 32'd0);
      cycles(4);
      chk("midrst_we",   32'(bus.mem_we), 32'd0);

      // 6. Address range and kept contents
      bus.cpu_addr = 32'h8000_0008;
      #1;
      chk("bit31_mem_addr", 32'(bus.mem_addr), 32'd2);
      chk("bit31_cpu_data", bus.cpu_data, 32'hA500_0002);
      bus.cpu_addr = 32'h0000_03fc;
      #1;
      chk("last_word", bus.cpu_data, 32'hA500_00FF);
      bus.cpu_addr = 32'h0000_0400;
      #1;
      chk("out_of_range", bus.cpu_data, 32'h0);
      bus.cpu_addr = 32'h0000_0000;
      #1;
      chk("loaded_word0", bus.cpu_data, 32'h1234_5678);
      bus.cpu_addr = 32'h0000_0004;
      #1;
      chk("loaded_word1", bus.cpu_data, 32'h0800_002d);

      cycles(2);
      n_cmp += mon_cmp;
      n_err += mon_err;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time controller for the CPU's writable instruction memory. It owns the memory's single address port and shares it between CPU instruction fetch and a UART-fed program loader. While a load is in progress it holds the CPU. On a successful load it releases the CPU so execution restarts from PC 0x00000000 with the new image.

## Interface
- `ROM_SIZE`, 256: instruction memory depth in words; must equal 2**`ADDR_W`.
- `ADDR_W`, 8: memory word-address width.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `load_req` in 1: load request; only its rising edge is acted on.
- `rx_data` in 8: received UART byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `cpu_addr` in 32: CPU fetch PC (byte address).
- `cpu_data` out 32: instruction returned to the CPU.
- `mem_addr` out `ADDR_W`: memory word address.
- `mem_rdata` in 32: memory read data, combinational from `mem_addr`.
- `mem_wdata` out 32: memory write data.
- `mem_we` out 1: memory write enable, one cycle per word.
- `cpu_hold` out 1: held high during a load; the top level ORs it into the CPU reset.
- `load_done` out 1: one-cycle pulse when a load succeeds.
- `load_err` out 1: high while in ERR.

## Operation
**States:** RUN, CNT_LO, CNT_HI, DATA, CHECK, DONE, ERR.

**Request detection**
- `load_req` is registered once; `rise = load_req & ~load_req_q`.

**RUN**
- `cpu_hold` = 0.
- `mem_addr` = `cpu_addr[ADDR_W+1:2]`.
- `cpu_data` = `mem_rdata` if `cpu_addr[30:2]` < `ROM_SIZE`, else 0. Bit 31 is ignored.
- `rx_valid` is ignored.
- `rise` → CNT_LO.

**CNT_LO / CNT_HI** (load header)
- Two bytes, little-endian, give the word count N (16 bits).
- On the CNT_HI byte: N == 0 or N > `ROM_SIZE` → ERR; otherwise → DATA.
- In CNT_HI, clear: word index, byte index, checksum.

**DATA**
- Each accepted byte is shifted into the assembly register, little-endian (first byte → bits 7:0), and XORed into the checksum.
- On the 4th byte of a word:
  - the assembled word is loaded into `mem_wdata`;
  - next cycle, `mem_we` = 1 with `mem_addr` = current word index;
  - the word index increments after that write.
- After word N−1 is accepted → CHECK.

**CHECK**
- Next byte equal to the checksum → DONE; unequal → ERR.

**DONE**
- For one cycle: `load_done` = 1, `cpu_hold` = 1.
- Then → RUN.

**ERR**
- `cpu_hold` = 1, `load_err` = 1.
- `rise` → CNT_LO, which clears `load_err`. Otherwise stays in ERR.

**All states other than RUN**
- `cpu_hold` = 1.
- `cpu_data` = 0 (NOP).
- `mem_addr` = word index.

## Timing
**Reset values:** state RUN; `cpu_hold`, `mem_we`, `load_done`, `load_err` = 0; `mem_wdata`, counters, checksum = 0.

**RUN-mode fetch:** fully combinational, zero-cycle latency from `cpu_addr` to `cpu_data`.

**Write latency:** `mem_we` is registered and asserts exactly one cycle after the `rx_valid` of the 4th byte.
- `mem_wdata` and `mem_addr` are stable during that cycle.
- A new `rx_valid` in that same cycle is accepted into the assembly register and does not corrupt the pending write.

**Byte rate:** `rx_valid` may arrive on back-to-back cycles; every strobe is accepted.

**`cpu_hold`:** asserts the cycle after `rise` is detected and deasserts the cycle after DONE.

**`rise` outside RUN and ERR:** ignored; the load in progress continues.

**Reset mid-load:** immediate return to RUN. Words already written are kept; the partially assembled word is discarded.

## Configuration
- `LOADER_CHECKSUM_EN` defined: the CHECK state exists and a trailing XOR byte is required.
- `LOADER_CHECKSUM_EN` undefined:
  - the last data word goes directly to DONE;
  - the checksum logic is removed;
  - `load_err` is raised only for a bad count.

## Test plan
1. **Reset and fetch:** after reset, `cpu_addr`=0x00000004 and `mem_rdata`=0x0800002d → `mem_addr`=1, `cpu_data`=0x0800002d; all other outputs 0.
2. **Good load:** `rise`, then bytes 02 00 | 03 00 00 08 | 2d 00 00 08 | 2e →
   - `mem_we` at addr 0 with 0x08000003;
   - `mem_we` at addr 1 with 0x0800002d;
   - `load_done` pulses once;
   - `cpu_hold` falls the next cycle.
3. **Bad checksum:** same stream with final byte 0x00 → both writes occur; `load_err`=1, `cpu_hold` stays 1, no `load_done`. A new `rise` clears `load_err`.
4. **Bad count:** count bytes 01 01 (N=257) → ERR the cycle after the second byte; `mem_we` never asserts. Repeat with 00 00 → same result.
5. **Reset mid-load:** `reset` after 2 data bytes → RUN, `cpu_hold`=0, no `mem_we`.
6. **Address range:** `cpu_addr`=0x80000008 → `cpu_data`=`mem_rdata` of word 2. `cpu_addr`=0x00000400 (index 256) → `cpu_data`=0.
